// File: rtl/sched_pkg.sv
// Shared types and limits for the voice frame scheduler.
// State encoding, accumulator sizing and 16-bit sample limits.
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    SAT,
    WRITE
  } state_e;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

  function automatic int acc_w(input int n);
    return 16 + $clog2(n);
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational saturation of a wide signed accumulator
// to the signed 16-bit sample range.
module sat_clip
  import sched_pkg::*;
#(
  parameter int W = 19
) (
  input  logic signed [W-1:0] acc,
  output logic        [15:0]  y
);

  localparam logic signed [W-1:0] MAXW = W'(SAMPLE_MAX);
  localparam logic signed [W-1:0] MINW = W'(SAMPLE_MIN);

  always_comb begin
    y = acc[15:0];
    if (acc > MAXW) y = SAMPLE_MAX;
    else if (acc < MINW) y = SAMPLE_MIN;
  end

endmodule

// File: rtl/voice_frame_scheduler.sv
// Per-frame voice poller/mixer feeding the I2S transmit FIFO.
// Optional REQ timeout enabled by defining VOICE_TIMEOUT_EN.
module voice_frame_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_VOICES  = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic                  LRCLK,
  input  logic [NUM_VOICES-1:0] VOICE_ACTIVE,
  input  logic [NUM_VOICES-1:0] VOICE_ACK,
  input  logic [15:0]           VOICE_DATA,
  input  logic                  FIFO_FULL,
  input  logic                  MUTE,
  input  logic                  STAT_CLR,
  output logic [NUM_VOICES-1:0] VOICE_REQ,
  output logic                  FIFO_WRITE,
  output logic [15:0]           FIFO_DATA,
  output logic                  BUSY,
  output logic [7:0]            DROP_CNT,
  output logic                  OVERRUN,
  output logic                  TIMEOUT
);

  localparam int AW = acc_w(NUM_VOICES);
  localparam int IW = $clog2(NUM_VOICES + 1);
  localparam int PW = 1 << IW;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [NUM_VOICES-1:0]  req_q, req_d;
  logic                   fifo_write_q, fifo_write_d;
  logic [15:0]            fifo_data_q, fifo_data_d;
  logic [7:0]             drop_q, drop_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q;
  logic                   lrclk_q, start_q;

  logic [PW-1:0]          act_pad, ack_pad;
  logic [NUM_VOICES-1:0]  onehot;
  logic [15:0]            clip;

  assign act_pad = PW'(VOICE_ACTIVE);
  assign ack_pad = PW'(VOICE_ACK);
  assign onehot  = NUM_VOICES'(1) << idx_q;

  sat_clip #(.W(AW)) u_sat (
    .acc (acc_q),
    .y   (clip)
  );

`ifdef VOICE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    req_d        = '0;
    fifo_write_d = 1'b0;
    fifo_data_d  = fifo_data_q;
    drop_d       = drop_q;
    overrun_d    = overrun_q;
`ifdef VOICE_TIMEOUT_EN
    tmo_d        = tmo_q;
    timeout_d    = timeout_q;
`endif
    // A rise seen mid-frame is flagged and otherwise dropped
    if (start_q && state_q != IDLE) overrun_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          idx_d   = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IW'(NUM_VOICES)) begin
          state_d = SAT;
        end else if (act_pad[idx_q]) begin
          state_d = REQ;
          req_d   = onehot;
`ifdef VOICE_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      REQ: begin
        if (ack_pad[idx_q]) begin
          acc_d   = acc_q + AW'($signed(VOICE_DATA));
          idx_d   = idx_q + IW'(1);
          state_d = SCAN;
`ifdef VOICE_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          idx_d     = idx_q + IW'(1);
          state_d   = SCAN;
        end else begin
          tmo_d = tmo_q + TW'(1);
          req_d = onehot;
`else
        end else begin
          req_d = onehot;
`endif
        end
      end
      SAT: begin
        state_d = WRITE;
        if (!FIFO_FULL) begin
          fifo_write_d = 1'b1;
          fifo_data_d  = MUTE ? 16'h0000 : clip;
        end else if (drop_q != 8'hff) begin
          drop_d = drop_q + 8'd1;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (STAT_CLR) begin
      drop_d    = '0;
      overrun_d = 1'b0;
`ifdef VOICE_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      req_q        <= '0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      drop_q       <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      req_q        <= req_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      drop_q       <= drop_d;
      overrun_q    <= overrun_d;
      busy_q       <= (state_d != IDLE);
      lrclk_q      <= LRCLK;
      start_q      <= LRCLK & ~lrclk_q;
    end
  end

`ifdef VOICE_TIMEOUT_EN
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign VOICE_REQ  = req_q;
  assign FIFO_WRITE = fifo_write_q;
  assign FIFO_DATA  = fifo_data_q;
  assign BUSY       = busy_q;
  assign DROP_CNT   = drop_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_voice_frame_scheduler.sv
// Scoreboard bench for voice_frame_scheduler (8 voices).
// Expected mixes come from a behavioural sum/clip model.
module tb_voice_frame_scheduler;

  logic        MCLK = 1'b0;
  logic        RESET, LRCLK, FIFO_FULL, MUTE, STAT_CLR;
  logic [7:0]  VOICE_ACTIVE, VOICE_ACK, VOICE_REQ, DROP_CNT;
  logic [15:0] VOICE_DATA, FIFO_DATA;
  logic        FIFO_WRITE, BUSY, OVERRUN, TIMEOUT;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int c0, nwrites, write_cyc, req3_cycles;
  logic [15:0] vdata [8];
  logic [7:0]  noack;
  logic [7:0]  prev_req;
  logic [15:0] exp_q [$];
  logic [7:0]  req_log [$];

  voice_frame_scheduler #(.NUM_VOICES(8), .TIMEOUT_CYC(15)) dut (
    .MCLK(MCLK), .RESET(RESET), .LRCLK(LRCLK),
    .VOICE_ACTIVE(VOICE_ACTIVE), .VOICE_ACK(VOICE_ACK),
    .VOICE_DATA(VOICE_DATA), .FIFO_FULL(FIFO_FULL),
    .MUTE(MUTE), .STAT_CLR(STAT_CLR), .VOICE_REQ(VOICE_REQ),
    .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA), .BUSY(BUSY),
    .DROP_CNT(DROP_CNT), .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  // Voice array model: answers its own request at once
  always_comb begin
    VOICE_ACK  = '0;
    VOICE_DATA = '0;
    for (int i = 0; i < 8; i++)
      if (VOICE_REQ[i] && !noack[i]) begin
        VOICE_ACK[i] = 1'b1;
        VOICE_DATA   = vdata[i];
      end
  end

  function automatic logic [15:0] model();
    longint s = 0;
    for (int i = 0; i < 8; i++)
      if (VOICE_ACTIVE[i] && !noack[i]) s += longint'($signed(vdata[i]));
    if (MUTE) return 16'h0000;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic run_frame(input int glitch);
    logic [15:0] e;
    bit done = 0;
    nwrites = 0; write_cyc = -1; req3_cycles = 0;
    prev_req = '0; req_log.delete();
    if (!FIFO_FULL) exp_q.push_back(model());
    @(negedge MCLK);
    LRCLK = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge MCLK);
      if (glitch > 0 && i == glitch) LRCLK = 1'b0;
      if (glitch > 0 && i == glitch + 2) LRCLK = 1'b1;
      if (FIFO_WRITE) begin
        nwrites++; write_cyc = cyc; tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write data=%h", FIFO_DATA);
        end else begin
          e = exp_q.pop_front();
          if (FIFO_DATA !== e) begin
            tests_failed++;
            $display("FAIL fifo_data got=%h exp=%h", FIFO_DATA, e);
          end
        end
      end
      if (VOICE_REQ != 0 && VOICE_REQ != prev_req) req_log.push_back(VOICE_REQ);
      if (VOICE_REQ == 8'h08) req3_cycles++;
      prev_req = VOICE_REQ;
      if (i >= 2 && !BUSY) done = 1;
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL frame_hang busy=%b exp=0", BUSY);
    end
    LRCLK = 1'b0;
    @(negedge MCLK);
  endtask

  task automatic test_reset();
    bit hit = 0;
    RESET = 1'b1; LRCLK = 0; FIFO_FULL = 0; MUTE = 0; STAT_CLR = 0;
    VOICE_ACTIVE = '0; noack = '0;
    for (int i = 0; i < 8; i++) vdata[i] = '0;
    repeat (3) @(negedge MCLK);
    tests_run++;
    if ({VOICE_REQ, FIFO_WRITE, FIFO_DATA, BUSY, DROP_CNT, OVERRUN, TIMEOUT} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs req=%h wr=%b data=%h busy=%b exp=0",
               VOICE_REQ, FIFO_WRITE, FIFO_DATA, BUSY);
    end
    RESET = 1'b0;
    // Park in REQ on voice 2, then reset underneath it
    VOICE_ACTIVE = 8'h04; noack = 8'h04;
    @(negedge MCLK); LRCLK = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge MCLK);
      if (VOICE_REQ == 8'h04) hit = 1;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL reach_req2 req=%h exp=04", VOICE_REQ);
    end
    #1 RESET = 1'b1;
    #1;
    tests_run++;
    if ({VOICE_REQ, FIFO_WRITE, BUSY, DROP_CNT, OVERRUN, TIMEOUT} !== '0) begin
      tests_failed++;
      $display("FAIL reset_midreq req=%h busy=%b exp=0", VOICE_REQ, BUSY);
    end
    LRCLK = 1'b0; noack = '0;
    @(negedge MCLK); RESET = 1'b0;
    @(negedge MCLK);
    VOICE_ACTIVE = 8'hff;
    for (int i = 0; i < 8; i++) vdata[i] = 16'(i + 1);
    run_frame(0);
    tests_run++;
    if (req_log.size() == 0 || req_log[0] !== 8'h01) begin
      tests_failed++;
      $display("FAIL post_reset_first_req got=%h exp=01",
               req_log.size() ? req_log[0] : 8'h00);
    end
  endtask

  task automatic test_sum();
    VOICE_ACTIVE = 8'hff;
    for (int i = 0; i < 8; i++) vdata[i] = 16'h0100;
    run_frame(0);
    tests_run++;
    if (FIFO_DATA !== 16'h0800) begin
      tests_failed++;
      $display("FAIL sum_data got=%h exp=0800", FIFO_DATA);
    end
    tests_run++;
    if (write_cyc - c0 !== 19) begin
      tests_failed++;
      $display("FAIL write_cycle got=%0d exp=19", write_cyc - c0);
    end
    tests_run++;
    if (nwrites !== 1) begin
      tests_failed++;
      $display("FAIL write_count got=%0d exp=1", nwrites);
    end
  endtask

  task automatic test_sat();
    VOICE_ACTIVE = 8'h0f;
    for (int i = 0; i < 8; i++) vdata[i] = 16'd30000;
    run_frame(0);
    tests_run++;
    if (FIFO_DATA !== 16'h7fff) begin
      tests_failed++;
      $display("FAIL sat_pos got=%h exp=7fff", FIFO_DATA);
    end
    VOICE_ACTIVE = 8'hff;
    for (int i = 0; i < 8; i++) vdata[i] = 16'h8000;
    run_frame(0);
    tests_run++;
    if (FIFO_DATA !== 16'h8000) begin
      tests_failed++;
      $display("FAIL sat_neg got=%h exp=8000", FIFO_DATA);
    end
    for (int k = 0; k < 4; k++) begin
      VOICE_ACTIVE = 8'($urandom);
      for (int i = 0; i < 8; i++) vdata[i] = 16'($urandom);
      run_frame(0);
    end
  endtask

  task automatic test_mask();
    logic [7:0] want [4] = '{8'h01, 8'h04, 8'h20, 8'h80};
    VOICE_ACTIVE = 8'b1010_0101;
    for (int i = 0; i < 8; i++) vdata[i] = 16'(100 * i);
    run_frame(0);
    tests_run++;
    if (req_log.size() !== 4) begin
      tests_failed++;
      $display("FAIL mask_count got=%0d exp=4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (req_log[i] !== want[i]) begin
          tests_failed++;
          $display("FAIL mask_order[%0d] got=%h exp=%h", i, req_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    VOICE_ACTIVE = 8'hff;
    for (int i = 0; i < 8; i++) vdata[i] = 16'(16 * i + 1);
`ifdef VOICE_TIMEOUT_EN
    noack = 8'h08;
    run_frame(0);
    tests_run++;
    if (TIMEOUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_flag got=%b exp=1", TIMEOUT);
    end
    tests_run++;
    if (req3_cycles !== 15) begin
      tests_failed++;
      $display("FAIL timeout_len got=%0d exp=15", req3_cycles);
    end
    tests_run++;
    if (req_log.size() !== 8 || req_log[3] !== 8'h08 || req_log[4] !== 8'h10) begin
      tests_failed++;
      $display("FAIL timeout_next size=%0d exp=8 after v3 req=%h exp=10",
               req_log.size(), req_log.size() > 4 ? req_log[4] : 8'h00);
    end
    noack = '0;
    @(negedge MCLK); STAT_CLR = 1'b1;
    @(negedge MCLK); STAT_CLR = 1'b0;
    tests_run++;
    if (TIMEOUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clr got=%b exp=0", TIMEOUT);
    end
`else
    run_frame(0);
    tests_run++;
    if (TIMEOUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_tied got=%b exp=0", TIMEOUT);
    end
`endif
  endtask

  task automatic test_mute();
    VOICE_ACTIVE = 8'h3c;
    for (int i = 0; i < 8; i++) vdata[i] = 16'h1234;
    MUTE = 1'b1;
    run_frame(0);
    MUTE = 1'b0;
    tests_run++;
    if (FIFO_DATA !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mute got=%h exp=0000", FIFO_DATA);
    end
  endtask

  task automatic test_drop();
    int total = 0;
    logic [15:0] held;
    VOICE_ACTIVE = 8'h01; vdata[0] = 16'h4321;
    run_frame(0);
    held = 16'h4321;
    FIFO_FULL = 1'b1; VOICE_ACTIVE = 8'h00;
    for (int f = 0; f < 300; f++) begin
      run_frame(0);
      total += nwrites;
      if (f == 0) begin
        tests_run++;
        if (DROP_CNT !== 8'd1) begin
          tests_failed++;
          $display("FAIL drop_first got=%0d exp=1", DROP_CNT);
        end
      end
    end
    tests_run++;
    if (total !== 0) begin
      tests_failed++;
      $display("FAIL drop_writes got=%0d exp=0", total);
    end
    tests_run++;
    if (DROP_CNT !== 8'd255) begin
      tests_failed++;
      $display("FAIL drop_sat got=%0d exp=255", DROP_CNT);
    end
    tests_run++;
    if (FIFO_DATA !== held) begin
      tests_failed++;
      $display("FAIL data_hold got=%h exp=%h", FIFO_DATA, held);
    end
    FIFO_FULL = 1'b0;
    @(negedge MCLK); STAT_CLR = 1'b1;
    @(negedge MCLK); STAT_CLR = 1'b0;
    tests_run++;
    if (DROP_CNT !== 8'd0) begin
      tests_failed++;
      $display("FAIL drop_clr got=%0d exp=0", DROP_CNT);
    end
  endtask

  task automatic test_back_to_back();
    VOICE_ACTIVE = 8'hff;
    for (int i = 0; i < 8; i++) vdata[i] = 16'h0010;
    run_frame(5);
    tests_run++;
    if (OVERRUN !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun got=%b exp=1", OVERRUN);
    end
    tests_run++;
    if (nwrites !== 1) begin
      tests_failed++;
      $display("FAIL overrun_writes got=%0d exp=1", nwrites);
    end
    repeat (6) @(negedge MCLK);
    tests_run++;
    if (BUSY !== 1'b0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL overrun_idle busy=%b pending=%0d exp=0/0", BUSY, exp_q.size());
    end
    STAT_CLR = 1'b1;
    @(negedge MCLK); STAT_CLR = 1'b0;
    tests_run++;
    if (OVERRUN !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clr got=%b exp=0", OVERRUN);
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_sat();
    test_mask();
    test_timeout();
    test_mute();
    test_drop();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL missing_writes got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
